// File: rtl/async_fifo_ctrl_pkg.sv
// Shared types and constants for the async FIFO write-side controller.
package async_fifo_ctrl_pkg;

    localparam int RST_CNT_W = 8;

    typedef enum logic [1:0] {
        HOLD,
        WAIT,
        IDLE,
        XFER
    } arb_state_t;

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last grant.
module async_fifo_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        winner_o = last_i;
        any_o    = 1'b0;
        idx      = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Write-side controller for async_fifo: packet-level round-robin sharing of the
// write port, plus FIFO reset/flush sequencing.
//
// state | meaning
// HOLD  | fifo_rst asserted, counting RST_CYCLES
// WAIT  | fifo_rst released, waiting for fifo_full to drop
// IDLE  | between packets; services flush, else picks next owner
// XFER  | owner streams beats until an accepted last
module async_fifo_wr_arb
    import async_fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush,
    output logic                          fifo_rst,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [RST_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     pick;
    logic                 pick_any;
    logic                 flush_pend_q, flush_pend_d;
    logic                 accept;
    logic                 owner_valid;
    logic                 owner_last;

    async_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req_valid),
        .last_i   (grant_q),
        .winner_o (pick),
        .any_o    (pick_any)
    );

    assign owner_valid  = req_valid[grant_q];
    assign owner_last   = req_last[grant_q];
    assign fifo_wr_data = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            HOLD: begin
                if (cnt_q == RST_CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (!fifo_full) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (flush_pend_q) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (pick_any) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                req_ready[grant_q] = !fifo_full;
                accept             = owner_valid && !fifo_full;
                if (accept && owner_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // A flush arriving on the very cycle HOLD is entered must still re-arm.
    assign flush_pend_d = flush ||
                          (flush_pend_q && !(state_d == HOLD && state_q != HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            grant_q      <= IDX_W'(NUM_REQ - 1);
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign fifo_wr_en = accept;
    assign fifo_rst   = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;

endmodule

// File: doc/async_fifo_wr_arb.md
# async_fifo_wr_arb

Write-side controller for `async_fifo`: shares the FIFO write port among `NUM_REQ` packet sources by round-robin arbitration at packet boundaries, and owns the FIFO's `rst` input. It sequences reset/flush: holds FIFO reset, waits for `full` to drop, then opens arbitration. It sits entirely in the write clock domain, between upstream producers and the FIFO's `wr_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: FIFO word width; must match the FIFO instance.
- `RST_CYCLES`, 4: cycles `fifo_rst` is held per reset/flush; legal range is 4..255.

Ports:
- `clk`  in  1  write-domain clock; FIFO `wr_clk` is the same net.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-source beat valid.
- `req_last`  in  NUM_REQ  per-source end-of-packet marker, qualified by valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-source beat accept.
- `flush`  in  1  single-cycle request to clear the FIFO.
- `fifo_rst`  out  1  drives FIFO `rst`.
- `fifo_wr_en`  out  1  drives FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_WIDTH  drives FIFO `wr_data`.
- `fifo_full`  in  1  FIFO `full`.
- `grant_id`  out  $clog2(NUM_REQ)  current or last owner.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
States:
- **HOLD**
  - Drives `fifo_rst`=1.
  - Counts `RST_CYCLES` cycles, then goes to WAIT.
- **WAIT**
  - Holds `fifo_rst`=0.
  - Stays until `fifo_full`=0 is sampled, then goes to IDLE.
- **IDLE**
  - If `flush_pend` is set, goes to HOLD. Flush has priority over requests.
  - Otherwise, if any `req_valid` is high, registers the round-robin winner into `grant_id` and goes to XFER.
- **XFER**
  - Owner handshake: `req_ready[grant_id]` = !`fifo_full`. All other `req_ready` bits are 0.
  - A beat is accepted when valid && ready.
  - When an accepted beat has last set, the next state is IDLE.

Datapath and arbitration:
- `fifo_wr_en` = accepted beat, combinational.
- `fifo_wr_data` = owner's `req_data` slice, combinational.
- The FIFO's own full handling is relied on, so `RESERVE`=0 is legal.
- Round-robin search starts at `grant_id`+1, modulo NUM_REQ.

Flush:
- A `flush` pulse sets the sticky `flush_pend`.
- It is serviced in IDLE only. A packet in flight always completes first.
- `flush_pend` clears on entry to HOLD. A second `flush` during HOLD/WAIT sets it again, which causes a second sequence.

## Timing
Reset values (async `rst` asserted):
- state=HOLD, counter=0, `fifo_rst`=1, `fifo_wr_en`=0.
- `req_ready`=0, `grant_id`=NUM_REQ-1, so source 0 has first priority.
- `busy`=1, `flush_pend`=0.

Latencies:
- `fifo_rst` is high for exactly `RST_CYCLES` cycles after `rst` release or after entering HOLD.
- WAIT→IDLE happens on the cycle after `fifo_full`=0 is sampled.
- `req_valid` seen in IDLE at cycle N → XFER at N+1. The first beat can be accepted at N+1.
- After a last beat at cycle M, the state is IDLE at M+1, so there is one bubble cycle per packet.

Boundary conditions:
- Valid dropping mid-packet: stay in XFER and keep ownership. There is no timeout.
- `fifo_full` during XFER: `req_ready`=0 and no write. The transfer resumes the cycle after full drops.
- `flush` in the same cycle as a last beat: the beat is accepted, then IDLE→HOLD.
- `rst` mid-packet: immediate HOLD, and the packet is lost.

## Structure
- Package `async_fifo_ctrl_pkg` holds:
  - the state enum `arb_state_t` {HOLD, WAIT, IDLE, XFER};
  - the `RST_CNT_W`=8 constant.
- Sub-module `async_fifo_rr_pick` (parameter NUM_REQ):
  - inputs: request vector and last grant;
  - outputs: winner index and `any` flag;
  - purely combinational.
- Top level contains the FSM, the `RST_CYCLES` counter, `flush_pend`, and the data mux.

## Test plan
- Bench instantiates `async_fifo` with DATA_WIDTH=8, ADDR_WIDTH=4 behind the arbiter.
- **Reset:** `rst` held for 10 cycles, then released → `fifo_rst` high for exactly 4 cycles; `busy` drops after `fifo_full`=0; FIFO pointers are 0.
- **Fairness:** all 4 sources continuously send 2-beat packets (data = 16*id + beat) → grant order 0,1,2,3,0; the read side sees unbroken packets in that order.
- **Backpressure:** source 1 sends a 20-beat packet while the read side is stalled → 16 beats written, `req_ready`=0 while full; after draining, beats 16..19 arrive in order and nothing is lost.
- **Flush mid-packet:** `flush` pulsed on beat 2 of a 5-beat packet → all 5 beats accepted, then a `fifo_rst` 4-cycle pulse; the FIFO reads empty afterwards.
- **Reset mid-transfer:** `rst` asserted during XFER → `req_ready`=0 and `fifo_rst`=1 in the same cycle; `grant_id`=3; the next grant goes to source 0.
- **Back-to-back single-beat packets:** source 2 sends single-beat packets with last=1 → one accepted beat every 2 cycles.
